accel_spi_responder: RTL and testbench
======================================

ACCEL_SPI_RESPONDER -- requirements
Module: accel_spi_responder

Interface
REQ-001 SHALL have parameter REG_RESET_POWER_CTL, default 8'h00, reset value of POWER_CTL register.
REQ-002 SHALL have ports: clk input 1 system clock (>= 8x SCLK frequency); rst input 1 reset.
REQ-003 SHALL have ports: acl_csn input 1; acl_sclk input 1; acl_mosi input 1; acl_miso output 1; acl_miso_oe output 1, high while the block drives acl_miso.
REQ-004 SHALL have ports: x_data, y_data, z_data input 8 each, live accelerometer sample values.
REQ-005 SHALL have ports: power_ctl output 8, current POWER_CTL value; soft_reset_pulse output 1; rd_count output 16, completed read bytes; wr_count output 16, completed write bytes.
REQ-006 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-007 SHALL pass acl_csn, acl_sclk and acl_mosi through a 2-flop synchronizer; edge detection (SCLK rise/fall, CSN fall/rise) SHALL operate on the synchronized signals.
REQ-008 SHALL implement SPI mode 0: sample MOSI on SCLK rise, update MISO on SCLK fall, MSB first.
REQ-009 SHALL use FSM states IDLE, CMD, ADDR, DATA_RD, DATA_WR, IGNORE with a 3-bit bit counter.
REQ-010 IDLE->CMD on CSN fall; a CSN rise in any state SHALL force IDLE and clear the bit counter within 1 clk of the detected edge.
REQ-011 After 8 rises in CMD: 8'h0B -> ADDR (read), 8'h0A -> ADDR (write), any other value -> IGNORE until CSN rise.
REQ-012 After 8 rises in ADDR, SHALL latch 8-bit address and enter DATA_RD or DATA_WR.
REQ-013 On the CSN fall, SHALL snapshot x_data, y_data, z_data; all reads in that transaction SHALL return the snapshot.
REQ-014 Register map: 0x00=8'hAD, 0x01=8'h1D, 0x02=8'hF2, 0x08=X, 0x09=Y, 0x0A=Z, 0x1F SOFT_RESET (write-only, reads 0), 0x2D POWER_CTL (R/W); all other addresses read 8'h00 and ignore writes.
REQ-015 Read: at the 8th ADDR rise, and at the 8th rise of each DATA_RD byte, SHALL load tx shift register with the register at the current address; each SCLK fall SHALL drive acl_miso from tx MSB then shift left.
REQ-016 Address SHALL auto-increment after each complete data byte, wrapping 8'hFF -> 8'h00.
REQ-017 Write: after 8 rises in DATA_WR, SHALL commit the byte to the addressed register in the same clk the byte completes.
REQ-018 Writing 8'h52 to 0x1F SHALL assert soft_reset_pulse for exactly 1 clk and restore POWER_CTL to REG_RESET_POWER_CTL; other values to 0x1F are ignored.
REQ-019 rd_count/wr_count SHALL increment by 1 per completed data byte, wrapping 16'hFFFF -> 0; partial bytes (CSN rise mid-byte) SHALL not count nor commit.
REQ-020 acl_miso SHALL be 0 outside DATA_RD and before the first fall following address completion; acl_miso_oe SHALL equal synchronized CSN low.
REQ-021 SCLK edges while CSN high SHALL be ignored.

Reset
REQ-022 rst SHALL set state IDLE, bit counter 0, acl_miso 0, acl_miso_oe 0, power_ctl REG_RESET_POWER_CTL, soft_reset_pulse 0, rd_count 0, wr_count 0, synchronizer flops to idle levels (CSN 1, SCLK 0, MOSI 0).
REQ-023 rst asserted mid-transaction SHALL abort it; the block SHALL stay in IDLE until a fresh CSN fall after rst deasserts.

Structure
REQ-024 Package accel_spi_pkg SHALL hold command codes (0x0A, 0x0B), register addresses, ID constants, soft-reset key 8'h52 and the FSM state enum.
REQ-025 One sub-module, spi_sync_edge, SHALL implement the 2-flop synchronizer plus rise/fall pulse outputs, instantiated per SPI input.

Verification
REQ-026 Read 0x0B,0x00, 3 bytes -> MISO returns 8'hAD, 8'h1D, 8'hF2; rd_count=3.
REQ-027 x_data=8'h12 at CSN fall, changed to 8'h34 mid-transaction, burst read 0x08..0x0A -> X returns 8'h12; next transaction returns 8'h34.
REQ-028 Write 0x0A,0x2D,8'h02 then read 0x2D -> 8'h02; wr_count=1, power_ctl=8'h02.
REQ-029 Write 0x0A,0x1F,8'h52 -> soft_reset_pulse high 1 clk, power_ctl back to 8'h00.
REQ-030 Write 0x0A,0x2D, CSN rise after 5 data bits -> power_ctl unchanged, wr_count unchanged, FSM IDLE.
REQ-031 Command 8'h0C followed by 16 SCLKs -> acl_miso stays 0, no counts change; read at 0xFF with 2 bytes -> 8'h00 then register 0x00 (8'hAD).

Source files
------------

// File: rtl/accel_spi_pkg.sv
// Shared constants, FSM encoding and register-read decode for the accelerometer SPI responder.
package accel_spi_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned BIT_CNT_W = 3;

    localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h0A;
    localparam logic [BYTE_W-1:0] CMD_READ  = 8'h0B;

    localparam logic [BYTE_W-1:0] ADDR_DEVID_AD   = 8'h00;
    localparam logic [BYTE_W-1:0] ADDR_DEVID_MST  = 8'h01;
    localparam logic [BYTE_W-1:0] ADDR_PARTID     = 8'h02;
    localparam logic [BYTE_W-1:0] ADDR_XDATA      = 8'h08;
    localparam logic [BYTE_W-1:0] ADDR_YDATA      = 8'h09;
    localparam logic [BYTE_W-1:0] ADDR_ZDATA      = 8'h0A;
    localparam logic [BYTE_W-1:0] ADDR_SOFT_RESET = 8'h1F;
    localparam logic [BYTE_W-1:0] ADDR_POWER_CTL  = 8'h2D;

    localparam logic [BYTE_W-1:0] ID_DEVID_AD  = 8'hAD;
    localparam logic [BYTE_W-1:0] ID_DEVID_MST = 8'h1D;
    localparam logic [BYTE_W-1:0] ID_PARTID    = 8'hF2;

    localparam logic [BYTE_W-1:0] SOFT_RESET_KEY = 8'h52;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ADDR    = 3'd2,
        DATA_RD = 3'd3,
        DATA_WR = 3'd4,
        IGNORE  = 3'd5
    } state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] x;
        logic [BYTE_W-1:0] y;
        logic [BYTE_W-1:0] z;
    } sample_t;

    // Read-side register map; SOFT_RESET and unmapped addresses read zero.
    function automatic logic [BYTE_W-1:0] reg_read(input logic [BYTE_W-1:0] addr,
                                                   input sample_t           snap,
                                                   input logic [BYTE_W-1:0] pwr);
        logic [BYTE_W-1:0] val;
        case (addr)
            ADDR_DEVID_AD:  val = ID_DEVID_AD;
            ADDR_DEVID_MST: val = ID_DEVID_MST;
            ADDR_PARTID:    val = ID_PARTID;
            ADDR_XDATA:     val = snap.x;
            ADDR_YDATA:     val = snap.y;
            ADDR_ZDATA:     val = snap.z;
            ADDR_POWER_CTL: val = pwr;
            default:        val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, with rise/fall pulses on the synchronized level.
module spi_sync_edge #(
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise_c,
    output logic fall_c
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= IDLE_LVL;
            sync <= IDLE_LVL;
            prev <= IDLE_LVL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise_c = sync & ~prev;
    assign fall_c = ~sync & prev;

endmodule

// File: rtl/accel_spi_responder.sv
// SPI mode-0 slave emulating a small accelerometer register file (ID, XYZ sample, POWER_CTL, SOFT_RESET).
module accel_spi_responder
    import accel_spi_pkg::*;
#(
    parameter logic [7:0] REG_RESET_POWER_CTL = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acl_csn,
    input  logic              acl_sclk,
    input  logic              acl_mosi,
    output logic              acl_miso,
    output logic              acl_miso_oe,
    input  logic [BYTE_W-1:0] x_data,
    input  logic [BYTE_W-1:0] y_data,
    input  logic [BYTE_W-1:0] z_data,
    output logic [BYTE_W-1:0] power_ctl,
    output logic              soft_reset_pulse,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    logic csn_s, csn_rise, csn_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, unused_mosi_rise, unused_mosi_fall;

    spi_sync_edge #(.IDLE_LVL(1'b1)) u_sync_csn (
        .clk(clk), .rst(rst), .din(acl_csn),
        .sync(csn_s), .rise_c(csn_rise), .fall_c(csn_fall)
    );

    spi_sync_edge #(.IDLE_LVL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(acl_sclk),
        .sync(sclk_s), .rise_c(sclk_rise), .fall_c(sclk_fall)
    );

    spi_sync_edge #(.IDLE_LVL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(acl_mosi),
        .sync(mosi_s), .rise_c(unused_mosi_rise), .fall_c(unused_mosi_fall)
    );

    state_e                 state_q, state_nxt;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_nxt;
    logic [BYTE_W-1:0]      rx_q, rx_nxt;
    logic [BYTE_W-1:0]      tx_q, tx_nxt;
    logic [BYTE_W-1:0]      addr_q, addr_nxt;
    logic                   wr_mode_q, wr_mode_nxt;
    sample_t                snap_q, snap_nxt;
    logic                   armed_q, armed_nxt;
    logic [1:0]             settle_q, settle_nxt;
    logic                   miso_nxt, miso_oe_nxt;
    logic [BYTE_W-1:0]      power_ctl_nxt;
    logic                   soft_reset_pulse_nxt;
    logic [CNT_W-1:0]       rd_count_nxt, wr_count_nxt;
    logic [BYTE_W-1:0]      rx_byte;
    logic                   last_bit;
    logic [BYTE_W-1:0]      addr_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            bit_cnt_q        <= '0;
            rx_q             <= '0;
            tx_q             <= '0;
            addr_q           <= '0;
            wr_mode_q        <= 1'b0;
            snap_q           <= '0;
            armed_q          <= 1'b0;
            settle_q         <= '0;
            acl_miso         <= 1'b0;
            acl_miso_oe      <= 1'b0;
            power_ctl        <= REG_RESET_POWER_CTL;
            soft_reset_pulse <= 1'b0;
            rd_count         <= '0;
            wr_count         <= '0;
        end else begin
            state_q          <= state_nxt;
            bit_cnt_q        <= bit_cnt_nxt;
            rx_q             <= rx_nxt;
            tx_q             <= tx_nxt;
            addr_q           <= addr_nxt;
            wr_mode_q        <= wr_mode_nxt;
            snap_q           <= snap_nxt;
            armed_q          <= armed_nxt;
            settle_q         <= settle_nxt;
            acl_miso         <= miso_nxt;
            acl_miso_oe      <= miso_oe_nxt;
            power_ctl        <= power_ctl_nxt;
            soft_reset_pulse <= soft_reset_pulse_nxt;
            rd_count         <= rd_count_nxt;
            wr_count         <= wr_count_nxt;
        end
    end

    // A CSN that was already low when rst released is not a fresh transaction start.
    always_comb begin
        state_nxt            = state_q;
        bit_cnt_nxt          = bit_cnt_q;
        rx_nxt               = rx_q;
        tx_nxt               = tx_q;
        addr_nxt             = addr_q;
        wr_mode_nxt          = wr_mode_q;
        snap_nxt             = snap_q;
        settle_nxt           = {settle_q[0], 1'b1};
        armed_nxt            = armed_q | (settle_q[1] & csn_s);
        miso_nxt             = acl_miso;
        miso_oe_nxt          = ~csn_s;
        power_ctl_nxt        = power_ctl;
        soft_reset_pulse_nxt = 1'b0;
        rd_count_nxt         = rd_count;
        wr_count_nxt         = wr_count;
        rx_byte              = {rx_q[BYTE_W-2:0], mosi_s};
        last_bit             = (bit_cnt_q == 3'd7);
        addr_inc             = addr_q + 8'd1;

        if (csn_rise) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
        end else if (csn_fall && state_q == IDLE && armed_q) begin
            state_nxt   = CMD;
            bit_cnt_nxt = '0;
            snap_nxt    = '{x: x_data, y: y_data, z: z_data};
        end else if (sclk_rise && !csn_s) begin
            if (state_q inside {CMD, ADDR, DATA_RD, DATA_WR}) begin
                rx_nxt      = rx_byte;
                bit_cnt_nxt = bit_cnt_q + 3'd1;
            end
            if (last_bit) begin
                case (state_q)
                    CMD: begin
                        if (rx_byte == CMD_READ) begin
                            state_nxt   = ADDR;
                            wr_mode_nxt = 1'b0;
                        end else if (rx_byte == CMD_WRITE) begin
                            state_nxt   = ADDR;
                            wr_mode_nxt = 1'b1;
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end
                    ADDR: begin
                        addr_nxt = rx_byte;
                        if (wr_mode_q) begin
                            state_nxt = DATA_WR;
                        end else begin
                            state_nxt = DATA_RD;
                            tx_nxt    = reg_read(rx_byte, snap_q, power_ctl);
                        end
                    end
                    DATA_RD: begin
                        addr_nxt     = addr_inc;
                        rd_count_nxt = rd_count + 16'd1;
                        tx_nxt       = reg_read(addr_inc, snap_q, power_ctl);
                    end
                    DATA_WR: begin
                        addr_nxt     = addr_inc;
                        wr_count_nxt = wr_count + 16'd1;
                        if (addr_q == ADDR_POWER_CTL) begin
                            power_ctl_nxt = rx_byte;
                        end else if (addr_q == ADDR_SOFT_RESET && rx_byte == SOFT_RESET_KEY) begin
                            power_ctl_nxt        = REG_RESET_POWER_CTL;
                            soft_reset_pulse_nxt = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (sclk_fall && !csn_s && state_q == DATA_RD) begin
            miso_nxt = tx_q[BYTE_W-1];
            tx_nxt   = {tx_q[BYTE_W-2:0], 1'b0};
        end

        if (state_nxt != DATA_RD) begin
            miso_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_accel_spi_responder.sv
// Directed bench: table of SPI transactions with expected read bytes and counters, plus corner sequences.
module tb_accel_spi_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        acl_csn, acl_sclk, acl_mosi;
    logic        acl_miso, acl_miso_oe;
    logic [7:0]  x_data, y_data, z_data;
    logic [7:0]  power_ctl;
    logic        soft_reset_pulse;
    logic [15:0] rd_count, wr_count;

    int n_cmp = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    int miso_hi_cnt = 0;

    accel_spi_responder #(.REG_RESET_POWER_CTL(8'h00)) dut (
        .clk(clk), .rst(rst),
        .acl_csn(acl_csn), .acl_sclk(acl_sclk), .acl_mosi(acl_mosi),
        .acl_miso(acl_miso), .acl_miso_oe(acl_miso_oe),
        .x_data(x_data), .y_data(y_data), .z_data(z_data),
        .power_ctl(power_ctl), .soft_reset_pulse(soft_reset_pulse),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (soft_reset_pulse) pulse_cnt <= pulse_cnt + 1;
        if (acl_miso)         miso_hi_cnt <= miso_hi_cnt + 1;
    end

    typedef struct {
        logic [7:0]      cmd;
        logic [7:0]      addr;
        int              n;
        logic [2:0][7:0] wd;
        logic [2:0][7:0] rd;
        logic [15:0]     rdc;
        logic [15:0]     wrc;
        logic [7:0]      pwr;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] cmd, addr, input int n,
                                input logic [7:0] b0, b1, b2,
                                input logic [15:0] rdc, wrc, input logic [7:0] pwr);
        vec_t v;
        v.cmd = cmd; v.addr = addr; v.n = n;
        v.wd[0] = b0; v.wd[1] = b1; v.wd[2] = b2;
        v.rd = v.wd;
        v.rdc = rdc; v.wrc = wrc; v.pwr = pwr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            acl_mosi = mo[i];
            wait_clks(HALF);
            mi[i] = acl_miso;
            acl_sclk = 1'b1;
            wait_clks(HALF);
            acl_sclk = 1'b0;
        end
    endtask

    task automatic csn_start();
        acl_csn = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic csn_end();
        wait_clks(HALF);
        acl_csn = 1'b1;
        wait_clks(2 * HALF);
    endtask

    vec_t       vecs[11];
    logic [7:0] got, dummy;
    int         base;

    initial begin
        rst = 1'b1; acl_csn = 1'b1; acl_sclk = 1'b0; acl_mosi = 1'b0;
        x_data = 8'h5A; y_data = 8'hA5; z_data = 8'h3C;
        wait_clks(5);
        check("reset miso", 32'(acl_miso), 32'h0);
        check("reset miso_oe", 32'(acl_miso_oe), 32'h0);
        check("reset power_ctl", 32'(power_ctl), 32'h00);
        check("reset pulse", 32'(soft_reset_pulse), 32'h0);
        check("reset rd_count", 32'(rd_count), 32'h0);
        check("reset wr_count", 32'(wr_count), 32'h0);
        rst = 1'b0;
        wait_clks(10);

        // cmd, addr, nbytes, data (write) / expected data (read), rd_count, wr_count, power_ctl after
        vecs[0]  = mk(8'h0B, 8'h00, 3, 8'hAD, 8'h1D, 8'hF2,  3, 0, 8'h00);
        vecs[1]  = mk(8'h0A, 8'h2D, 1, 8'h02, 8'h00, 8'h00,  3, 1, 8'h02);
        vecs[2]  = mk(8'h0B, 8'h2D, 1, 8'h02, 8'h00, 8'h00,  4, 1, 8'h02);
        vecs[3]  = mk(8'h0B, 8'h08, 3, 8'h5A, 8'hA5, 8'h3C,  7, 1, 8'h02);
        vecs[4]  = mk(8'h0B, 8'h1E, 3, 8'h00, 8'h00, 8'h00, 10, 1, 8'h02);
        vecs[5]  = mk(8'h0A, 8'h1F, 1, 8'h11, 8'h00, 8'h00, 10, 2, 8'h02);
        vecs[6]  = mk(8'h0B, 8'hFF, 2, 8'h00, 8'hAD, 8'h00, 12, 2, 8'h02);
        vecs[7]  = mk(8'h0A, 8'h00, 1, 8'h77, 8'h00, 8'h00, 12, 3, 8'h02);
        vecs[8]  = mk(8'h0B, 8'h00, 1, 8'hAD, 8'h00, 8'h00, 13, 3, 8'h02);
        vecs[9]  = mk(8'h0A, 8'h2C, 2, 8'h99, 8'h0F, 8'h00, 13, 5, 8'h0F);
        vecs[10] = mk(8'h0B, 8'h2C, 2, 8'h00, 8'h0F, 8'h00, 15, 5, 8'h0F);

        for (int v = 0; v < 11; v++) begin
            csn_start();
            spi_bits(vecs[v].cmd, 8, dummy);
            spi_bits(vecs[v].addr, 8, dummy);
            for (int j = 0; j < vecs[v].n; j++) begin
                spi_bits(vecs[v].wd[j], 8, got);
                if (vecs[v].cmd == 8'h0B)
                    check($sformatf("vec%0d byte%0d", v, j), 32'(got), 32'(vecs[v].rd[j]));
            end
            csn_end();
            check($sformatf("vec%0d rd_count", v), 32'(rd_count), 32'(vecs[v].rdc));
            check($sformatf("vec%0d wr_count", v), 32'(wr_count), 32'(vecs[v].wrc));
            check($sformatf("vec%0d power_ctl", v), 32'(power_ctl), 32'(vecs[v].pwr));
        end
        check("no pulse on non-key write", 32'(pulse_cnt), 32'h0);

        // Snapshot taken at CSN fall survives a mid-transaction change of x_data.
        x_data = 8'h12;
        csn_start();
        x_data = 8'h34;
        spi_bits(8'h0B, 8, dummy);
        spi_bits(8'h08, 8, dummy);
        spi_bits(8'h00, 8, got); check("snap x", 32'(got), 32'h12);
        spi_bits(8'h00, 8, got); check("snap y", 32'(got), 32'hA5);
        spi_bits(8'h00, 8, got); check("snap z", 32'(got), 32'h3C);
        csn_end();
        csn_start();
        spi_bits(8'h0B, 8, dummy);
        spi_bits(8'h08, 8, dummy);
        spi_bits(8'h00, 8, got); check("next snap x", 32'(got), 32'h34);
        csn_end();
        check("snap rd_count", 32'(rd_count), 32'd19);

        // Soft-reset key restores POWER_CTL with a single-cycle pulse.
        base = pulse_cnt;
        csn_start();
        spi_bits(8'h0A, 8, dummy);
        spi_bits(8'h1F, 8, dummy);
        spi_bits(8'h52, 8, dummy);
        csn_end();
        check("soft reset pulse cycles", 32'(pulse_cnt - base), 32'd1);
        check("soft reset power_ctl", 32'(power_ctl), 32'h00);
        check("soft reset wr_count", 32'(wr_count), 32'd6);

        // Partial write byte neither commits nor counts.
        csn_start();
        spi_bits(8'h0A, 8, dummy); spi_bits(8'h2D, 8, dummy); spi_bits(8'h02, 8, dummy);
        csn_end();
        check("pre-partial power_ctl", 32'(power_ctl), 32'h02);
        csn_start();
        spi_bits(8'h0A, 8, dummy); spi_bits(8'h2D, 8, dummy); spi_bits(8'hFF, 5, dummy);
        csn_end();
        check("partial power_ctl", 32'(power_ctl), 32'h02);
        check("partial wr_count", 32'(wr_count), 32'd7);
        csn_start();
        spi_bits(8'h0B, 8, dummy); spi_bits(8'h2D, 8, dummy); spi_bits(8'h00, 8, got);
        csn_end();
        check("after partial read", 32'(got), 32'h02);
        check("after partial rd_count", 32'(rd_count), 32'd20);

        // Unknown command: MISO quiet, counters untouched.
        base = miso_hi_cnt;
        csn_start();
        check("oe during transaction", 32'(acl_miso_oe), 32'h1);
        spi_bits(8'h0C, 8, dummy); spi_bits(8'h0B, 8, dummy); spi_bits(8'h00, 8, dummy);
        csn_end();
        check("ignore miso quiet", 32'(miso_hi_cnt - base), 32'd0);
        check("ignore rd_count", 32'(rd_count), 32'd20);
        check("ignore wr_count", 32'(wr_count), 32'd7);
        check("oe after csn high", 32'(acl_miso_oe), 32'h0);

        // rst in the middle of a read aborts it; block waits for a fresh CSN fall.
        csn_start();
        spi_bits(8'h0B, 8, dummy); spi_bits(8'h00, 4, dummy);
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        base = miso_hi_cnt;
        spi_bits(8'h00, 4, dummy);
        spi_bits(8'hFF, 8, dummy);
        spi_bits(8'hFF, 8, dummy);
        check("rst abort miso quiet", 32'(miso_hi_cnt - base), 32'd0);
        check("rst abort rd_count", 32'(rd_count), 32'd0);
        check("rst abort wr_count", 32'(wr_count), 32'd0);
        check("rst abort power_ctl", 32'(power_ctl), 32'h00);
        csn_end();
        csn_start();
        spi_bits(8'h0B, 8, dummy); spi_bits(8'h01, 8, dummy); spi_bits(8'h00, 8, got);
        csn_end();
        check("post-rst read 0x01", 32'(got), 32'h1D);
        check("post-rst rd_count", 32'(rd_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
